// File: rtl/id_operand_stage.sv
// Decode-side operand stage: one valid/ready slot that resolves rs1/rs2 from
// prioritised forwarding sources or the register file, with interlock and stall counter.

module id_opnd_resolve #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [4:0]              rs_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [XLEN-1:0]         rf_rdata_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD-1:0]      fwd_we_i,
    input  logic [NUM_FWD-1:0]      fwd_ready_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
    output logic [XLEN-1:0]         val_o,
    output logic                    hazard_o
);
    logic            rdy;
    logic [XLEN-1:0] val;

    // Walk from lowest priority up so the youngest matching source is left standing.
    always_comb begin
        val = rf_rdata_i;
        rdy = 1'b1;
        for (int i = NUM_FWD-1; i >= 0; i--) begin
            if (fwd_valid_i[i] && fwd_we_i[i] && (fwd_rd_i[5*i +: 5] != 5'd0) &&
                (fwd_rd_i[5*i +: 5] == rs_i)) begin
                val = fwd_data_i[XLEN*i +: XLEN];
                rdy = fwd_ready_i[i];
            end
        end
    end

    assign val_o    = (rs_i == 5'd0) ? '0 : val;
    assign hazard_o = v_i && en_i && !rdy;
endmodule

module id_operand_stage #(
    parameter int XLEN      = 32,
    parameter int NUM_FWD   = 3,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [PAYLOAD_W-1:0]    in_payload_i,
    input  logic [4:0]              in_rs1_i,
    input  logic [4:0]              in_rs2_i,
    input  logic                    in_rs1_en_i,
    input  logic                    in_rs2_en_i,
    input  logic                    flush_i,
    output logic [4:0]              rf_raddr1_o,
    output logic [4:0]              rf_raddr2_o,
    input  logic [XLEN-1:0]         rf_rdata1_i,
    input  logic [XLEN-1:0]         rf_rdata2_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD-1:0]      fwd_we_i,
    input  logic [NUM_FWD-1:0]      fwd_ready_i,
    input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PAYLOAD_W-1:0]    out_payload_o,
    output logic [XLEN-1:0]         out_rs1_val_o,
    output logic [XLEN-1:0]         out_rs2_val_o,
    output logic                    hazard_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);
    logic                  v_q, v_d;
    logic [PAYLOAD_W-1:0]  payload_q;
    logic [1:0][4:0]       rs_q;
    logic [1:0]            en_q;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic [1:0][XLEN-1:0]  rf_rdata;
    logic [1:0][XLEN-1:0]  opnd;
    logic [1:0]            haz;
    logic                  go, capture;

    assign rf_rdata[0] = rf_rdata1_i;
    assign rf_rdata[1] = rf_rdata2_i;

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        id_opnd_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_res (
            .rs_i        (rs_q[g]),
            .en_i        (en_q[g]),
            .v_i         (v_q),
            .rf_rdata_i  (rf_rdata[g]),
            .fwd_valid_i (fwd_valid_i),
            .fwd_we_i    (fwd_we_i),
            .fwd_ready_i (fwd_ready_i),
            .fwd_rd_i    (fwd_rd_i),
            .fwd_data_i  (fwd_data_i),
            .val_o       (opnd[g]),
            .hazard_o    (haz[g])
        );
    end

    assign hazard_o    = |haz;
    assign go          = !hazard_o;
    assign out_valid_o = v_q && go;
    assign in_ready_o  = !v_q || (go && out_ready_i);
    assign capture     = in_valid_i && in_ready_o && !flush_i;

    assign rf_raddr1_o   = rs_q[0];
    assign rf_raddr2_o   = rs_q[1];
    assign out_payload_o = payload_q;
    assign out_rs1_val_o = opnd[0];
    assign out_rs2_val_o = opnd[1];
    assign stall_cnt_o   = stall_cnt_q;

    always_comb begin
        v_d = v_q;
        if (flush_i)                          v_d = 1'b0;
        else if (capture)                     v_d = 1'b1;
        else if (out_valid_o && out_ready_i)  v_d = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_o && !flush_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q         <= 1'b0;
            payload_q   <= '0;
            rs_q        <= '0;
            en_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
            if (capture) begin
                payload_q <= in_payload_i;
                rs_q[0]   <= in_rs1_i;
                rs_q[1]   <= in_rs2_i;
                en_q[0]   <= in_rs1_en_i;
                en_q[1]   <= in_rs2_en_i;
            end
        end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboarded bench for id_operand_stage: directed vectors push expected hand-offs,
// a negedge monitor pops and compares; a CNT_W=4 instance covers saturation.

module tb_id_operand_stage;
    localparam int XLEN = 32, NF = 3, PW = 64;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [PW-1:0] in_payload = '0;
    logic [4:0] in_rs1 = '0, in_rs2 = '0;
    logic in_rs1_en = 1'b0, in_rs2_en = 1'b0;
    logic [XLEN-1:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic [NF-1:0] fwd_valid = '0, fwd_we = '0, fwd_ready = '0;
    logic [5*NF-1:0] fwd_rd = '0;
    logic [XLEN*NF-1:0] fwd_data = '0;

    logic in_ready, out_valid, hazard;
    logic [4:0] rf_raddr1, rf_raddr2;
    logic [PW-1:0] out_payload;
    logic [XLEN-1:0] out_rs1_val, out_rs2_val;
    logic [15:0] stall_cnt;

    logic s_in_ready, s_out_valid, s_hazard;
    logic [4:0] s_raddr1, s_raddr2;
    logic [PW-1:0] s_payload;
    logic [XLEN-1:0] s_rs1_val, s_rs2_val;
    logic [3:0] s_stall_cnt;

    int errors = 0, checks = 0;

    typedef struct { logic [PW-1:0] p; logic [XLEN-1:0] a; logic [XLEN-1:0] b; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF), .PAYLOAD_W(PW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_payload_i(in_payload), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_rs1_en_i(in_rs1_en), .in_rs2_en_i(in_rs2_en), .flush_i(flush),
        .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
        .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
        .fwd_valid_i(fwd_valid), .fwd_we_i(fwd_we), .fwd_ready_i(fwd_ready),
        .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_payload_o(out_payload),
        .out_rs1_val_o(out_rs1_val), .out_rs2_val_o(out_rs2_val),
        .hazard_o(hazard), .stall_cnt_o(stall_cnt));

    id_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF), .PAYLOAD_W(PW), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .in_payload_i(in_payload), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_rs1_en_i(in_rs1_en), .in_rs2_en_i(in_rs2_en), .flush_i(flush),
        .rf_raddr1_o(s_raddr1), .rf_raddr2_o(s_raddr2),
        .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
        .fwd_valid_i(fwd_valid), .fwd_we_i(fwd_we), .fwd_ready_i(fwd_ready),
        .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_payload_o(s_payload),
        .out_rs1_val_o(s_rs1_val), .out_rs2_val_o(s_rs2_val),
        .hazard_o(s_hazard), .stall_cnt_o(s_stall_cnt));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_fwd(input int i, input logic rdy, input logic [4:0] rd,
                           input logic [XLEN-1:0] d);
        fwd_valid[i] = 1'b1;
        fwd_we[i]    = 1'b1;
        fwd_ready[i] = rdy;
        fwd_rd[5*i +: 5] = rd;
        fwd_data[XLEN*i +: XLEN] = d;
    endtask

    task automatic clr_fwd();
        fwd_valid = '0; fwd_we = '0; fwd_ready = '0; fwd_rd = '0; fwd_data = '0;
    endtask

    task automatic issue(input logic [PW-1:0] p, input logic [4:0] r1, input logic [4:0] r2,
                         input logic e1, input logic e2);
        in_valid = 1'b1; in_payload = p;
        in_rs1 = r1; in_rs2 = r2; in_rs1_en = e1; in_rs2_en = e2;
    endtask

    // Monitor: every accepted hand-off must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_handoff: got payload 0x%0h expected none", out_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_payload", out_payload, e.p);
                chk("sb_rs1_val", {32'd0, out_rs1_val}, {32'd0, e.a});
                chk("sb_rs2_val", {32'd0, out_rs2_val}, {32'd0, e.b});
            end
        end
    end

    logic [PW-1:0]   hold_p;
    logic [XLEN-1:0] hold_a, hold_b;

    initial begin
        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst_hazard",    {63'd0, hazard}, 64'd0);
        chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        chk("rst_payload",   out_payload, 64'd0);
        tick(); rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // Plain register-file operands, one-cycle latency
        tick();
        rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        issue(64'h1000_0000_0000_1004, 5'd5, 5'd6, 1'b1, 1'b1);
        sb.push_back('{64'h1000_0000_0000_1004, 32'h11, 32'h22});
        @(negedge clk);
        chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_raddr1", {59'd0, rf_raddr1}, 64'd5);
        chk("t1_raddr2", {59'd0, rf_raddr2}, 64'd6);

        // Priority + x0, then back-to-back
        tick();
        set_fwd(0, 1'b1, 5'd5, 32'hAA);
        set_fwd(2, 1'b1, 5'd5, 32'hBB);
        set_fwd(1, 1'b1, 5'd0, 32'hCC);
        rf_rdata2 = 32'h77;
        issue(64'h2000_0000_0000_2004, 5'd5, 5'd0, 1'b1, 1'b1);
        sb.push_back('{64'h2000_0000_0000_2004, 32'hAA, 32'h0});
        @(negedge clk);
        chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        issue(64'h3000_0000_0000_3004, 5'd6, 5'd5, 1'b1, 1'b1);
        sb.push_back('{64'h3000_0000_0000_3004, 32'h11, 32'hAA});
        @(negedge clk);
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_valid", {63'd0, out_valid}, 64'd1);
        tick(); clr_fwd();

        // Interlock: youngest source unready, older ready source must not win
        set_fwd(0, 1'b0, 5'd7, 32'h0);
        set_fwd(1, 1'b1, 5'd7, 32'h99);
        issue(64'h4000_0000_0000_4004, 5'd3, 5'd7, 1'b1, 1'b1);
        sb.push_back('{64'h4000_0000_0000_4004, 32'h11, 32'h55});
        tick(); in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hazard", {63'd0, hazard}, 64'd1);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd0);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        fwd_ready[0] = 1'b1; fwd_data[31:0] = 32'h55;
        @(negedge clk);
        chk("stall_cnt_3", {48'd0, stall_cnt}, 64'd3);
        chk("stall_release_hazard", {63'd0, hazard}, 64'd0);
        chk("stall_release_valid", {63'd0, out_valid}, 64'd1);
        tick();

        // Unread operand never interlocks
        set_fwd(0, 1'b0, 5'd7, 32'h66);
        issue(64'h5000_0000_0000_5004, 5'd3, 5'd7, 1'b1, 1'b0);
        sb.push_back('{64'h5000_0000_0000_5004, 32'h11, 32'h66});
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("noen_hazard", {63'd0, hazard}, 64'd0);
        chk("noen_stall_cnt", {48'd0, stall_cnt}, 64'd3);
        tick(); clr_fwd();

        // Backpressure then flush
        out_ready = 1'b0;
        issue(64'h6000_0000_0000_6004, 5'd5, 5'd6, 1'b1, 1'b1);
        tick();
        issue(64'h7000_0000_0000_7004, 5'd8, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        hold_p = out_payload; hold_a = out_rs1_val; hold_b = out_rs2_val;
        chk("bp_payload", out_payload, 64'h6000_0000_0000_6004);
        tick();
        @(negedge clk);
        chk("bp_payload_stable", out_payload, hold_p);
        chk("bp_rs1_stable", {32'd0, out_rs1_val}, {32'd0, hold_a});
        chk("bp_rs2_stable", {32'd0, out_rs2_val}, {32'd0, hold_b});
        chk("bp_in_ready2", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("flush_no_capture", {63'd0, out_valid}, 64'd0);
        chk("flush_payload", out_payload, 64'h6000_0000_0000_6004);

        // Saturation and reset mid-stall
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        tick();
        set_fwd(0, 1'b0, 5'd9, 32'h0);
        issue(64'h8000_0000_0000_8004, 5'd9, 5'd0, 1'b1, 1'b0);
        tick(); in_valid = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("sat_big_cnt", {48'd0, stall_cnt}, 64'd20);
        chk("sat_small_cnt", {60'd0, s_stall_cnt}, 64'd15);
        chk("sat_hazard", {63'd0, hazard}, 64'd1);
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stall_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_stall_hazard", {63'd0, hazard}, 64'd0);
        chk("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        chk("rst_stall_small_cnt", {60'd0, s_stall_cnt}, 64'd0);
        clr_fwd();
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-side operand stage. It holds one decoded instruction in a valid/ready pipeline slot and resolves its two source operands. Each operand comes from one of NUM_FWD prioritised forwarding sources or from the register file. It interlocks when the matching producer's data is not yet available, and supports flush. It sits between the fetch/decode register and the execute stage, replacing the fixed three-source bypass and load-only interlock with a generic per-source readiness flag and a stall performance counter.

## Interface
- XLEN, 32: operand data width.
- NUM_FWD, 3: number of forwarding sources; index 0 = youngest (highest priority).
- PAYLOAD_W, 64: width of opaque payload (pc, pc+4, control) carried alongside.
- CNT_W, 16: stall counter width.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream holds a decoded instruction.
- in_ready  out  1  slot can accept this cycle.
- in_payload  in  PAYLOAD_W  opaque payload.
- in_rs1, in_rs2  in  5 each  source register indices.
- in_rs1_en, in_rs2_en  in  1 each  operand is actually read.
- flush  in  1  discard held and incoming instruction.
- rf_raddr1, rf_raddr2  out  5 each  held rs1/rs2, to register-file read ports.
- rf_rdata1, rf_rdata2  in  XLEN each  combinational register-file read data.
- fwd_valid, fwd_we, fwd_ready  in  NUM_FWD each  per source: slot valid, writes rd, data available.
- fwd_rd  in  5*NUM_FWD  per-source destination, source i at [5i+4:5i].
- fwd_data  in  XLEN*NUM_FWD  per-source result, source i at [XLEN*i+XLEN-1:XLEN*i].
- out_valid  out  1  operands resolved, instruction presented downstream.
- out_ready  in  1  downstream accepts.
- out_payload  out  PAYLOAD_W  held payload.
- out_rs1_val, out_rs2_val  out  XLEN each  resolved operands.
- hazard  out  1  interlock active this cycle.
- stall_cnt  out  CNT_W  saturating count of interlock cycles.

## Operation
- State: v (slot valid), held payload, rs1, rs2, rs1_en, rs2_en, stall_cnt.
- Source i matches rsN when fwd_valid[i] && fwd_we[i] && fwd_rd[i]!=0 && fwd_rd[i]==rsN.
- Operand resolution:
  - The lowest-index matching source wins.
  - If there is no match, use rf_rdata.
  - If rsN==0, the operand is 0 regardless of rf_rdata.
- Hazard on operand N: v && rsN_en && the winning source has fwd_ready=0. A lower-priority ready source never overrides an unready winner.
- hazard = hazard1 || hazard2; go = !hazard.
- out_valid = v && go; in_ready = !v || (go && out_ready).
- Capture: when in_valid && in_ready && !flush, load payload and indices; v<=1.
- Hand-off without refill: when out_valid && out_ready and no capture, v<=0.
- Flush (highest priority): v<=0 next cycle, and any transfer presented in the same cycle is discarded. in_ready is not gated by flush.
- stall_cnt increments by 1 each cycle hazard=1 && !flush. It saturates at all-ones and is cleared only by reset.
- Operands are resolved combinationally every cycle, so a stalled instruction picks up data the cycle fwd_ready rises.

## Timing
- Reset values: v=0, so out_valid=0, in_ready=1, hazard=0. stall_cnt=0; held payload, rs1, rs2 and the enables are all 0.
- Latency: an instruction accepted in cycle T is presented with out_valid=1 in T+1 if there is no hazard.
- Back-to-back: with out_ready=1 and no hazard, one instruction per cycle; in_ready stays 1.
- out_payload and out_rsN_val must stay stable while out_valid && !out_ready.
- Reset mid-stall: the slot empties and the counter clears the next cycle.
- Simultaneous hand-off and capture: the new instruction replaces the old with no bubble.

## Test plan
- Reset, then no input -> out_valid=0, in_ready=1, stall_cnt=0.
- Accept rs1=5, rs2=6, rf_rdata1=0x11, rf_rdata2=0x22, no forwarding -> next cycle out_valid=1, operands 0x11/0x22.
- rs1=5 with source0 (rd=5, data 0xAA, ready) and source2 (rd=5, data 0xBB) -> out_rs1_val=0xAA. With rs1=0 and source0 rd=0 -> operand 0.
- Source0 rd=7, fwd_ready=0 for 3 cycles, then 1 with data 0x55; instruction rs2=7, rs2_en=1 -> hazard=1, out_valid=0, in_ready=0 for 3 cycles, stall_cnt=3; then out_valid=1, out_rs2_val=0x55. With rs2_en=0 -> no hazard.
- out_ready=0 for 2 cycles with out_valid=1 -> payload and operands stable, in_ready=0. Then flush=1 with in_valid=1 -> next cycle out_valid=0, incoming instruction not captured.
- CNT_W=4, hazard held for 20 cycles -> stall_cnt saturates at 15.
